// File: rtl/spi_bridge_pkg.sv
// rtl/spi_bridge_pkg.sv - shared types and defaults for the SPI register bridge
package spi_bridge_pkg;

  typedef enum logic [2:0] {
    ST_CMD,
    ST_WDATA,
    ST_WCOMMIT,
    ST_RDATA,
    ST_RFETCH,
    ST_RCAPT
  } state_t;

  localparam int         CMD_RW_BIT         = 7;
  localparam logic [7:0] STATUS_DEFAULT     = 8'hA5;
  localparam int         DATA_BYTES_DEFAULT = 4;

endpackage

// File: rtl/spi_word_shift.sv
// rtl/spi_word_shift.sv - write word assembly, MSB-first read byte select, byte index
module spi_word_shift
  import spi_bridge_pkg::*;
#(
  parameter  int DATA_BYTES = DATA_BYTES_DEFAULT,
  localparam int W          = 8 * DATA_BYTES,
  localparam int IDX_W      = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr_shift,
  input  logic             rd_step,
  input  logic             rd_load,
  input  logic [7:0]       rx_data,
  input  logic [W-1:0]     rdata,
  output logic [W-1:0]     wdata,
  output logic [7:0]       next_byte,
  output logic [IDX_W-1:0] byte_idx,
  output logic             last_byte
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BYTES - 1);

  logic [W-1:0] rd_word;
  logic [W-1:0] rd_shifted;

  assign last_byte  = (byte_idx == LAST_IDX);
  // Byte following the one currently on the wire; on load it is the MSB of the fresh word.
  assign rd_shifted = rd_word << ((32'(byte_idx) + 32'd1) << 3);
  assign next_byte  = rd_load ? rdata[W-1 -: 8] : rd_shifted[W-1 -: 8];

  always_ff @(posedge clk) begin
    if (!rst) begin
      byte_idx <= '0;
      wdata    <= '0;
      rd_word  <= '0;
    end else begin
      if (clr) begin
        byte_idx <= '0;
      end else if (wr_shift || rd_step) begin
        byte_idx <= last_byte ? '0 : byte_idx + 1'b1;
      end
      if (wr_shift) begin
        wdata <= W'({wdata, rx_data});
      end
      if (rd_load) begin
        rd_word <= rdata;
      end
    end
  end

endmodule

// File: rtl/spi_reg_bridge.sv
// rtl/spi_reg_bridge.sv - SPI byte stream to register bus frame decoder
module spi_reg_bridge
  import spi_bridge_pkg::*;
#(
  parameter int         ADDR_W     = 7,
  parameter int         DATA_BYTES = DATA_BYTES_DEFAULT,
  parameter logic [7:0] STATUS     = STATUS_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    spi_ss,
  input  logic                    rx_strobe,
  input  logic [7:0]              rx_data,
  input  logic                    tx_strobe,
  output logic [7:0]              tx_data,
  output logic [ADDR_W-1:0]       reg_addr,
  output logic [8*DATA_BYTES-1:0] reg_wdata,
  output logic                    reg_wr,
  output logic                    reg_rd,
  input  logic [8*DATA_BYTES-1:0] reg_rdata,
  input  logic                    err_clr,
  output logic                    frame_err,
  output logic                    rd_late
);

  localparam int IDX_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

  state_t           state;
  logic [IDX_W-1:0] byte_idx;
  logic             last_byte;
  logic [7:0]       next_byte;
  logic             wr_shift;
  logic             rd_step;
  logic             rd_load;
  logic             frame_err_set;
  logic             rd_late_set;

  assign wr_shift      = !spi_ss && rx_strobe && (state == ST_WDATA);
  assign rd_step       = !spi_ss && rx_strobe && (state == ST_RDATA);
  assign rd_load       = !spi_ss && (state == ST_RCAPT);
  assign frame_err_set = spi_ss && (state == ST_WDATA) && (byte_idx != '0);
  assign rd_late_set   = tx_strobe && ((state == ST_RFETCH) || (state == ST_RCAPT));

  spi_word_shift #(
    .DATA_BYTES(DATA_BYTES)
  ) u_word_shift (
    .clk       (clk),
    .rst       (rst),
    .clr       (spi_ss),
    .wr_shift  (wr_shift),
    .rd_step   (rd_step),
    .rd_load   (rd_load),
    .rx_data   (rx_data),
    .rdata     (reg_rdata),
    .wdata     (reg_wdata),
    .next_byte (next_byte),
    .byte_idx  (byte_idx),
    .last_byte (last_byte)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_CMD;
      reg_addr <= '0;
      reg_wr   <= 1'b0;
      reg_rd   <= 1'b0;
      tx_data  <= STATUS;
    end else begin
      reg_wr <= 1'b0;
      reg_rd <= 1'b0;
      if (spi_ss) begin
        // A write pulse already on the bus this cycle still lands; nothing new is issued.
        state   <= ST_CMD;
        tx_data <= STATUS;
      end else begin
        case (state)
          ST_CMD: begin
            tx_data <= STATUS;
            if (rx_strobe) begin
              reg_addr <= ADDR_W'(rx_data[6:0]);
              if (rx_data[CMD_RW_BIT]) begin
                state  <= ST_RFETCH;
                reg_rd <= 1'b1;
              end else begin
                state <= ST_WDATA;
              end
            end
          end
          ST_WDATA: begin
            if (rx_strobe && last_byte) begin
              state  <= ST_WCOMMIT;
              reg_wr <= 1'b1;
            end
          end
          ST_WCOMMIT: begin
            reg_addr <= reg_addr + 1'b1;
            state    <= ST_WDATA;
          end
          ST_RFETCH: begin
            state <= ST_RCAPT;
          end
          ST_RCAPT: begin
            tx_data <= next_byte;
            state   <= ST_RDATA;
          end
          ST_RDATA: begin
            if (rx_strobe) begin
              if (last_byte) begin
                reg_addr <= reg_addr + 1'b1;
                reg_rd   <= 1'b1;
                state    <= ST_RFETCH;
              end else begin
                tx_data <= next_byte;
              end
            end
          end
          default: state <= ST_CMD;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      frame_err <= 1'b0;
      rd_late   <= 1'b0;
    end else begin
      frame_err <= frame_err_set || (frame_err && !err_clr);
      rd_late   <= rd_late_set || (rd_late && !err_clr);
    end
  end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb/tb_spi_reg_bridge.sv - directed self-checking bench for spi_reg_bridge
module tb_spi_reg_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_ss;
  logic        rx_strobe;
  logic [7:0]  rx_data;
  logic        tx_strobe;
  logic [7:0]  tx_data;
  logic [6:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_wr;
  logic        reg_rd;
  logic [31:0] reg_rdata = 32'h0;
  logic        err_clr;
  logic        frame_err;
  logic        rd_late;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] data;
    logic [6:0]  exp_addr;
    logic [31:0] exp_wdata;
  } wvec_t;

  typedef struct {
    logic [6:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t wlog[$];

  spi_reg_bridge dut (
    .clk       (clk),
    .rst       (rst),
    .spi_ss    (spi_ss),
    .rx_strobe (rx_strobe),
    .rx_data   (rx_data),
    .tx_strobe (tx_strobe),
    .tx_data   (tx_data),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_wr    (reg_wr),
    .reg_rd    (reg_rd),
    .reg_rdata (reg_rdata),
    .err_clr   (err_clr),
    .frame_err (frame_err),
    .rd_late   (rd_late)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_model(input logic [6:0] a);
    case (a)
      7'h05:   return 32'hDEADBEEF;
      7'h06:   return 32'h01234567;
      default: return 32'h0;
    endcase
  endfunction

  // Register slave: data valid only in the cycle right after reg_rd.
  always @(posedge clk) begin
    reg_rdata <= reg_rd ? rd_model(reg_addr) : 32'h0;
    if (reg_wr) wlog.push_back('{reg_addr, reg_wdata});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    repeat (n) tick();
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_data   = b;
    rx_strobe = 1'b1;
    tick();
    rx_strobe = 1'b0;
  endtask

  task automatic pulse_tx(output logic [7:0] seen);
    seen      = tx_data;
    tx_strobe = 1'b1;
    tick();
    tx_strobe = 1'b0;
  endtask

  task automatic write_frame(input wvec_t v);
    logic [31:0] d;
    spi_ss = 1'b0;
    tick();
    send_rx(v.cmd);
    d = v.data;
    for (int b = 0; b < 4; b++) begin
      gap(3);
      send_rx(d[31:24]);
      d = d << 8;
    end
    check("wr_pulse", 32'(reg_wr), 32'd1);
    check("wr_addr", 32'(reg_addr), 32'(v.exp_addr));
    check("wr_data", reg_wdata, v.exp_wdata);
    check("wr_tx_status", 32'(tx_data), 32'hA5);
    gap(2);
    spi_ss = 1'b1;
    tick();
  endtask

  wvec_t vecs[4];
  logic [7:0] seen;
  logic [7:0] exp_rd[4];
  int n;

  initial begin
    vecs[0] = '{8'h05, 32'h11223344, 7'h05, 32'h11223344};
    vecs[1] = '{8'h00, 32'hFFFFFFFF, 7'h00, 32'hFFFFFFFF};
    vecs[2] = '{8'h7F, 32'h00000001, 7'h7F, 32'h00000001};
    vecs[3] = '{8'h2A, 32'hA5A55A5A, 7'h2A, 32'hA5A55A5A};
    exp_rd[0] = 8'hDE; exp_rd[1] = 8'hAD; exp_rd[2] = 8'hBE; exp_rd[3] = 8'hEF;

    rst = 1'b0; spi_ss = 1'b1; rx_strobe = 1'b0; rx_data = 8'h0;
    tx_strobe = 1'b0; err_clr = 1'b0;
    gap(2);
    check("rst_tx", 32'(tx_data), 32'hA5);
    check("rst_addr", 32'(reg_addr), 32'h0);
    check("rst_wdata", reg_wdata, 32'h0);
    check("rst_wr_rd", 32'({reg_wr, reg_rd}), 32'h0);
    check("rst_flags", 32'({frame_err, rd_late}), 32'h0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) write_frame(vecs[i]);
    check("table_wr_count", 32'(wlog.size()), 32'd4);

    // Burst with address wrap 7F -> 00
    n = wlog.size();
    spi_ss = 1'b0;
    tick();
    send_rx(8'h7F);
    for (int b = 0; b < 8; b++) begin
      gap(3);
      send_rx(8'h11 * 8'(b + 1));
    end
    gap(3);
    spi_ss = 1'b1;
    tick();
    check("burst_count", 32'(wlog.size()), 32'(n + 2));
    if (wlog.size() == n + 2) begin
      check("burst0_addr", 32'(wlog[n].addr), 32'h7F);
      check("burst0_data", wlog[n].data, 32'h11223344);
      check("burst1_addr", 32'(wlog[n+1].addr), 32'h00);
      check("burst1_data", wlog[n+1].data, 32'h55667788);
    end

    // Read: latency, MSB-first bytes, next word fetch
    spi_ss = 1'b0;
    tick();
    pulse_tx(seen);
    check("rd_tx_status", 32'(seen), 32'hA5);
    gap(3);
    send_rx(8'h85);
    check("rd_pulse", 32'(reg_rd), 32'd1);
    check("rd_addr", 32'(reg_addr), 32'h05);
    tick();
    check("rd_pulse_once", 32'(reg_rd), 32'd0);
    tick();
    check("rd_first_byte", 32'(tx_data), 32'hDE);
    tick();
    for (int b = 0; b < 4; b++) begin
      pulse_tx(seen);
      check($sformatf("rd_byte%0d", b), 32'(seen), 32'(exp_rd[b]));
      gap(3);
      send_rx(8'h00);
      if (b < 3) gap(3);
    end
    check("rd2_pulse", 32'(reg_rd), 32'd1);
    check("rd2_addr", 32'(reg_addr), 32'h06);
    gap(2);
    check("rd2_first_byte", 32'(tx_data), 32'h01);
    gap(2);
    // Read aborted mid-word is not a framing error
    tick();
    pulse_tx(seen);
    gap(3);
    send_rx(8'h00);
    spi_ss = 1'b1;
    tick();
    check("rd_abort_no_err", 32'(frame_err), 32'd0);
    check("rd_abort_tx", 32'(tx_data), 32'hA5);

    // rd_late: tx_strobe during fetch; frame continues with fetched data
    spi_ss = 1'b0;
    tick();
    send_rx(8'h85);
    tx_strobe = 1'b1;
    tick();
    tx_strobe = 1'b0;
    check("rd_late_set", 32'(rd_late), 32'd1);
    tick();
    check("rd_late_continue", 32'(tx_data), 32'hDE);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("rd_late_clr", 32'(rd_late), 32'd0);
    spi_ss = 1'b1;
    tick();
    spi_ss = 1'b0;
    tick();
    send_rx(8'h85);
    tx_strobe = 1'b1;
    err_clr = 1'b1;
    tick();
    tx_strobe = 1'b0;
    err_clr = 1'b0;
    check("rd_late_set_wins", 32'(rd_late), 32'd1);
    spi_ss = 1'b1;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // Abort a write mid-word
    n = wlog.size();
    spi_ss = 1'b0;
    tick();
    send_rx(8'h05);
    gap(3);
    send_rx(8'h11);
    gap(3);
    send_rx(8'h22);
    gap(3);
    spi_ss = 1'b1;
    tick();
    check("abort_frame_err", 32'(frame_err), 32'd1);
    gap(2);
    check("abort_no_wr", 32'(wlog.size()), 32'(n));
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("abort_clr", 32'(frame_err), 32'd0);
    write_frame('{8'h05, 32'h11223344, 7'h05, 32'h11223344});

    // Reset in the middle of a write
    n = wlog.size();
    spi_ss = 1'b0;
    tick();
    send_rx(8'h10);
    gap(3);
    send_rx(8'hAA);
    gap(3);
    send_rx(8'hBB);
    rst = 1'b0;
    tick();
    check("mid_rst_wr_rd", 32'({reg_wr, reg_rd}), 32'h0);
    check("mid_rst_addr", 32'(reg_addr), 32'h0);
    check("mid_rst_wdata", reg_wdata, 32'h0);
    check("mid_rst_tx", 32'(tx_data), 32'hA5);
    rst = 1'b1;
    tick();
    write_frame('{8'h05, 32'hCAFEF00D, 7'h05, 32'hCAFEF00D});
    check("mid_rst_wr_count", 32'(wlog.size()), 32'(n + 1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
